// File: rtl/four_bit_cla_registered_adder_pkg.sv
// -----------------------------------------------------------------------------
// four_bit_cla_registered_adder_pkg
//
// Shared definitions for the registered 4-bit carry-lookahead adder:
//   WIDTH            - operand width (fixed at 4)
//   REG_RESET_VALUE  - value every datapath register takes in reset
//   operand_t        - one unsigned operand
//   operands_t       - the input-stage register bundle {a, b, cin}
//   result_t         - the output-stage register bundle {cout, sum}
// -----------------------------------------------------------------------------
package four_bit_cla_registered_adder_pkg;

    localparam int WIDTH = 4;

    localparam logic [WIDTH-1:0] REG_RESET_VALUE = '0;

    typedef logic [WIDTH-1:0] operand_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        logic     cin;
    } operands_t;

    typedef struct packed {
        logic     cout;
        operand_t sum;
    } result_t;

    localparam operands_t OPERANDS_RESET = '{
        a:   REG_RESET_VALUE,
        b:   REG_RESET_VALUE,
        cin: 1'b0
    };

    localparam result_t RESULT_RESET = '{
        cout: 1'b0,
        sum:  REG_RESET_VALUE
    };

endpackage : four_bit_cla_registered_adder_pkg

// File: rtl/four_bit_cla_registered_adder_cla4_core.sv
// -----------------------------------------------------------------------------
// cla4_core
//
// Purely combinational 4-bit carry-lookahead adder core.
//   a    [in]  operand A (unsigned)
//   b    [in]  operand B (unsigned)
//   cin  [in]  carry-in
//   sum  [out] (a + b + cin) mod 16
//   cout [out] carry-out, set when a + b + cin >= 16
//
// Every carry is written as a flat two-level sum-of-products of generate,
// propagate and cin, so no carry waits on another carry.
// -----------------------------------------------------------------------------
module cla4_core
    import four_bit_cla_registered_adder_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;   // generate: this bit produces a carry on its own
    logic [WIDTH-1:0] p;   // propagate: this bit passes an incoming carry on
    logic [WIDTH:0]   c;   // c[i] is the carry into bit i, c[4] is carry-out

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        c = '0;

        c[0] = cin;

        c[1] = g[0]
             | (p[0] & cin);

        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);

        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule : cla4_core

// File: rtl/four_bit_cla_registered_adder.sv
// -----------------------------------------------------------------------------
// four_bit_cla_registered_adder
//
// Two-stage registered 4-bit adder built around a carry-lookahead core.
//   clk    [in]  rising-edge clock
//   rst_n  [in]  asynchronous active-low reset, clears every register
//   a      [in]  operand A (unsigned, 4 bits)
//   b      [in]  operand B (unsigned, 4 bits)
//   cin    [in]  carry-in
//   sum    [out] registered (a + b + cin) mod 16
//   cout   [out] registered carry-out
//
// Pipeline: inputs are captured on edge N, added combinationally during the
// following cycle and the result is captured on edge N+1. A new operand set
// is accepted every cycle; there is no stall and no bypass. sum and cout come
// straight from flip-flops.
// -----------------------------------------------------------------------------
module four_bit_cla_registered_adder
    import four_bit_cla_registered_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    operands_t        operands_q;   // input stage: a_q, b_q, cin_q
    result_t          result_q;     // output stage: cout, sum
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    // Input stage.
    // NOTE: the reset sits in the sensitivity list so rst_n clears the register without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is always written with <= so every register samples the pre-edge values.
            operands_q <= OPERANDS_RESET;
        end else begin
            operands_q <= '{a: a, b: b, cin: cin};
        end
    end

    cla4_core u_core (
        .a    (operands_q.a),
        .b    (operands_q.b),
        .cin  (operands_q.cin),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // Output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= RESULT_RESET;
        end else begin
            result_q <= '{cout: cout_c, sum: sum_c};
        end
    end

    assign sum  = result_q.sum;
    assign cout = result_q.cout;

endmodule : four_bit_cla_registered_adder

// File: tb/tb_four_bit_cla_registered_adder.sv
// -----------------------------------------------------------------------------
// tb_four_bit_cla_registered_adder
//
// Inputs change on the falling edge. At each falling edge the output is
// compared with the scoreboard entry pushed two falling edges earlier, then
// new inputs are driven and the output is checked once more to confirm it
// did not move with the inputs.
// -----------------------------------------------------------------------------
module tb_four_bit_cla_registered_adder;
    import four_bit_cla_registered_adder_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    always #5 clk = ~clk;

    four_bit_cla_registered_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    // Expected {cout, sum}, one entry per cycle of stimulus.
    logic [4:0] sb_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [4:0] ref_add(input logic [3:0] va, input logic [3:0] vb,
                                           input logic vc);
        ref_add = 5'(va) + 5'(vb) + 5'(vc);
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got cout=%b sum=%0d, expected cout=%b sum=%0d (t=%0t)",
                     name, act[4], act[3:0], exp[4], exp[3:0], $time);
        end
    endtask

    // One cycle of stimulus: check the due result, drive new inputs,
    // confirm the output did not follow the inputs, queue the new result.
    task automatic step(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                        input logic [4:0] vexp, input string tag);
        logic [4:0] due;
        @(negedge clk);
        due = 5'd0;
        if (sb_q.size() >= 2) begin
            due = sb_q.pop_front();
            check(tag, {cout, sum}, due);
        end else begin
            check({tag, " scoreboard depth"}, 5'(sb_q.size()), 5'd2);
        end
        a   = va;
        b   = vb;
        cin = vc;
        sb_q.push_back(vexp);
        #1;
        check({tag, " stable after input change"}, {cout, sum}, due);
    endtask

    // Release at a falling edge: the next rising edge only loads the inputs,
    // so the output stays zero for one more cycle, then shows the held inputs.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        sb_q.push_back(5'd0);
        sb_q.push_back(ref_add(a, b, cin));
    endtask

    task automatic hold_reset_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check({tag, " after rising edge"}, {cout, sum}, 5'd0);
            @(negedge clk);
            check({tag, " at falling edge"}, {cout, sum}, 5'd0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        // Directed stream, then boundaries; expected values worked by hand.
        vecs[0] = '{a: 4'd1,  b: 4'd1,  cin: 1'b0, exp_sum: 4'd2,  exp_cout: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd3,  cin: 1'b1, exp_sum: 4'd7,  exp_cout: 1'b0};
        vecs[2] = '{a: 4'd7,  b: 4'd5,  cin: 1'b0, exp_sum: 4'd12, exp_cout: 1'b0};
        vecs[3] = '{a: 4'd15, b: 4'd1,  cin: 1'b1, exp_sum: 4'd1,  exp_cout: 1'b1};
        vecs[4] = '{a: 4'd5,  b: 4'd3,  cin: 1'b1, exp_sum: 4'd9,  exp_cout: 1'b0};
        vecs[5] = '{a: 4'd15, b: 4'd15, cin: 1'b1, exp_sum: 4'd15, exp_cout: 1'b1};
        vecs[6] = '{a: 4'd15, b: 4'd0,  cin: 1'b1, exp_sum: 4'd0,  exp_cout: 1'b1};
        vecs[7] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, exp_sum: 4'd0,  exp_cout: 1'b0};

        // Reset with all-ones inputs while the clock runs.
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        cin   = 1'b1;
        #1;
        check("reset before first edge", {cout, sum}, 5'd0);
        hold_reset_cycles(4, "reset held");

        // First result after release is the held 15+15+1, preceded by a zero cycle.
        release_reset();
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum},
                 $sformatf("vector %0d (%0d+%0d+%0d)", i, vecs[i].a, vecs[i].b, vecs[i].cin));
        end
        step(4'd0, 4'd0, 1'b0, 5'd0, "drain 0");
        step(4'd0, 4'd0, 1'b0, 5'd0, "drain 1");

        // Mid-stream reset: 9+9 is on the outputs, 6+7+1 is in the input stage.
        step(4'd9, 4'd9, 1'b0, ref_add(4'd9, 4'd9, 1'b0), "pre-reset 9+9+0");
        step(4'd6, 4'd7, 1'b1, ref_add(4'd6, 4'd7, 1'b1), "pre-reset 6+7+1");
        @(posedge clk);
        #1;
        check("in-flight result before reset", {cout, sum}, ref_add(4'd9, 4'd9, 1'b0));
        #1;
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        cin   = 1'b1;
        #1;
        check("mid-stream reset clears at once", {cout, sum}, 5'd0);
        hold_reset_cycles(3, "mid-stream reset held");

        // Nothing from before the reset may surface after release.
        release_reset();

        // Exhaustive sweep, one operand set per cycle.
        for (int k = 0; k < 512; k++) begin
            logic [3:0] va;
            logic [3:0] vb;
            logic       vc;
            va = 4'(k >> 5);
            vb = 4'(k >> 1);
            vc = k[0];
            step(va, vb, vc, ref_add(va, vb, vc),
                 $sformatf("sweep %0d+%0d+%0d", va, vb, vc));
        end
        step(4'd0, 4'd0, 1'b0, 5'd0, "final drain 0");
        step(4'd0, 4'd0, 1'b0, 5'd0, "final drain 1");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_four_bit_cla_registered_adder

// File: doc/four_bit_cla_registered_adder.md
FOUR_BIT_CLA_REGISTERED_ADDER -- requirements
Module: four_bit_cla_registered_adder

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, taken from the shared package constant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  4  operand A, unsigned.
REQ-005 b  input  4  operand B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 sum  output  4  registered sum.
REQ-008 cout  output  1  registered carry-out.

Function
REQ-009 Input stage SHALL capture a, b, cin into a_q, b_q, cin_q on every rising clk edge; no enable, no bypass.
REQ-010 Combinational core SHALL compute {cout_c, sum_c} = a_q + b_q + cin_q as a 5-bit unsigned result; sum_c = low 4 bits, cout_c = bit 4.
REQ-011 Core SHALL use carry-lookahead: g[i] = a_q[i] & b_q[i], p[i] = a_q[i] ^ b_q[i], sum_c[i] = p[i] ^ c[i], c[0] = cin_q.
REQ-012 Each carry c[1..4] SHALL be a flattened two-level sum-of-products of g, p and cin_q, e.g. c[2] = g1 | p1&g0 | p1&p0&cin_q; no carry term SHALL depend on another computed carry (no ripple chain).
REQ-013 Output stage SHALL capture sum_c into sum and cout_c into cout on every rising clk edge.
REQ-014 Latency SHALL be exactly 2 rising edges: inputs sampled at edge N appear on sum/cout after edge N+1 and stay stable until edge N+2.
REQ-015 Throughput SHALL be one new operand set per clock; back-to-back inputs SHALL never stall or be dropped.
REQ-016 Overflow SHALL wrap: sum = (a+b+cin) mod 16, cout = 1 iff a+b+cin >= 16.
REQ-017 Maximum case 15+15+1 SHALL give sum=4'hF, cout=1; zero case 0+0+0 SHALL give sum=0, cout=0.
REQ-018 Outputs SHALL be driven only by flip-flops; no combinational path from any input to sum or cout.

Reset
REQ-019 rst_n low SHALL immediately, without waiting for clk, clear a_q, b_q, cin_q, sum, cout to 0.
REQ-020 While rst_n is low all registers SHALL hold 0, ignoring clk and inputs.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight operands; no partial result SHALL appear after release.
REQ-022 After rst_n rises, the first edge SHALL load inputs; their result SHALL appear after the second edge; until then sum=0, cout=0.

Structure
REQ-023 Shared package SHALL hold WIDTH = 4 and the register reset value (all zeros).
REQ-024 Combinational CLA core SHALL be one sub-module, cla4_core (a, b, cin -> sum, cout; no clock); the registers SHALL stay in the top level.
REQ-025 Flip-flops SHALL be written as always_ff with asynchronous active-low reset; no latches, no gated clocks.

Verification
REQ-026 Reset: hold rst_n=0 with a=4'hF, b=4'hF, cin=1 and toggle clk -> sum=0, cout=0 throughout; assert rst_n mid-stream -> outputs go to 0 immediately.
REQ-027 Directed stream, one set per cycle after reset release: (1,1,0), (3,3,1), (7,5,0), (15,1,1), (5,3,1) -> two edges later sum/cout = (2,0), (7,0), (12,0), (1,1), (9,0) on consecutive cycles.
REQ-028 Boundaries: (15,15,1) -> sum=15, cout=1; (15,0,1) -> sum=0, cout=1; (0,0,0) -> sum=0, cout=0.
REQ-029 Exhaustive: all 512 combinations of (a, b, cin), one per cycle -> each result matches a reference adder exactly 2 edges later.
REQ-030 Latency/no-glitch: change inputs between edges only -> sum/cout change only right after rising edges and never earlier than 2 edges after inputs are applied.
